// File: rtl/serv_pc_seq_pkg.sv
// Shared definitions for the bit-serial PC sequencer: counter width, state
// encoding and the datapath-width legality check.
package serv_pc_seq_pkg;

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT_RF = 2'd2,
        RUN     = 2'd3
    } seq_state_e;

    function automatic bit w_legal(input int unsigned w);
        return (w == 32'd1) || (w == 32'd4);
    endfunction

endpackage

// File: rtl/serv_bitcnt.sv
// Serial bit counter: steps by W per active cycle, wraps at 32, and decodes
// the phase strobes from the registered count.
module serv_bitcnt
    import serv_pc_seq_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt0,
    output logic             o_cnt1,
    output logic             o_cnt2,
    output logic             o_cnt12to31,
    output logic             o_cnt_done
);

    localparam bit               SERIAL = (W == 32'd1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(32 - W);
    localparam logic [CNT_W-1:0] STEP   = CNT_W'(W);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Natural 5-bit overflow provides the 32-W -> 0 wrap.
    assign cnt_d = cnt_q + STEP;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt       = cnt_q;
    assign o_cnt0      = i_en & (cnt_q == '0);
    assign o_cnt1      = SERIAL & i_en & (cnt_q == CNT_W'(1));
    assign o_cnt2      = SERIAL & i_en & (cnt_q == CNT_W'(2));
    assign o_cnt12to31 = i_en & (cnt_q >= CNT_W'(12));
    assign o_cnt_done  = i_en & (cnt_q == LAST);

endmodule

// File: rtl/serv_pc_seq.sv
// PC sequencer: fetch handshake, register-file wait and one or two serial
// passes per instruction, driving the bit counter and PC shift enable.
module serv_pc_seq
    import serv_pc_seq_pkg::*;
#(
    parameter int unsigned W            = 1,
    parameter bit          TWO_STAGE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             i_rst,
    output logic             o_ibus_cyc,
    input  logic             i_ibus_ack,
    input  logic             i_rf_ready,
    input  logic             i_two_stage,
    output logic             o_init,
    output logic             o_cnt_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt0,
    output logic             o_cnt1,
    output logic             o_cnt2,
    output logic             o_cnt12to31,
    output logic             o_cnt_done,
    output logic             o_pc_en
);

    if (!w_legal(W)) begin : g_w_illegal
        $error("serv_pc_seq: W must be 1 or 4");
    end

    seq_state_e state_q;
    logic       ibus_cyc_q;
    logic       cnt_en_q;
    logic       init_q;
    logic       cnt_done;

    serv_bitcnt #(.W(W)) u_bitcnt (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_en        (cnt_en_q),
        .o_cnt       (o_cnt),
        .o_cnt0      (o_cnt0),
        .o_cnt1      (o_cnt1),
        .o_cnt2      (o_cnt2),
        .o_cnt12to31 (o_cnt12to31),
        .o_cnt_done  (cnt_done)
    );

    // init_q doubles as the stored two-stage flag: set at ack, cleared after pass one.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ibus_cyc_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    ibus_cyc_q <= 1'b1;
                end
                FETCH: begin
                    if (i_ibus_ack) begin
                        state_q    <= WAIT_RF;
                        ibus_cyc_q <= 1'b0;
                        init_q     <= i_two_stage & TWO_STAGE_EN;
                    end
                end
                WAIT_RF: begin
                    if (i_rf_ready) begin
                        state_q  <= RUN;
                        cnt_en_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_done) begin
                        cnt_en_q <= 1'b0;
                        if (init_q) begin
                            init_q  <= 1'b0;
                            state_q <= WAIT_RF;
                        end else begin
                            state_q    <= FETCH;
                            ibus_cyc_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ibus_cyc = ibus_cyc_q;
    assign o_cnt_en   = cnt_en_q;
    assign o_init     = init_q;
    assign o_cnt_done = cnt_done;
    assign o_pc_en    = cnt_en_q & ~init_q;

endmodule

// File: tb/tb_serv_pc_seq.sv
// Bench for serv_pc_seq: three instances (W=1, W=4, W=1 single-pass only)
// share stimulus and are compared each cycle against a behavioural model.
module tb_serv_pc_seq;

    typedef struct packed {
        logic       cyc;
        logic       init;
        logic       en;
        logic [4:0] cnt;
        logic       c0;
        logic       c1;
        logic       c2;
        logic       c12;
        logic       done;
        logic       pc;
    } obs_t;

    typedef struct {
        bit booted;
        bit fetching;
        bit waiting;
        bit first;
        int beat;
    } mdl_t;

    typedef struct {
        int   cyc_no;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ack = 1'b0;
    logic rf  = 1'b0;
    logic ts  = 1'b0;

    int   checks = 0;
    int   errors = 0;
    obs_t obs [3];
    mdl_t m   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned GW = (g == 1) ? 4 : 1;
        localparam bit          GT = (g != 2);
        logic       cyc, init, en, c0, c1, c2, c12, done, pc;
        logic [4:0] cnt;
        serv_pc_seq #(.W(GW), .TWO_STAGE_EN(GT)) u_dut (
            .clk         (clk),
            .i_rst       (rst),
            .o_ibus_cyc  (cyc),
            .i_ibus_ack  (ack),
            .i_rf_ready  (rf),
            .i_two_stage (ts),
            .o_init      (init),
            .o_cnt_en    (en),
            .o_cnt       (cnt),
            .o_cnt0      (c0),
            .o_cnt1      (c1),
            .o_cnt2      (c2),
            .o_cnt12to31 (c12),
            .o_cnt_done  (done),
            .o_pc_en     (pc)
        );
        assign obs[g] = {cyc, init, en, cnt, c0, c1, c2, c12, done, pc};
    end

    function automatic int wof(input int g);
        return (g == 1) ? 4 : 1;
    endfunction

    function automatic bit tseof(input int g);
        return (g != 2);
    endfunction

    function automatic mdl_t m_reset();
        mdl_t r;
        r.booted   = 1'b0;
        r.fetching = 1'b0;
        r.waiting  = 1'b0;
        r.first    = 1'b0;
        r.beat     = -1;
        return r;
    endfunction

    // Instruction lifecycle: boot -> fetch -> wait operands -> 32/w beats (x1 or x2).
    function automatic mdl_t m_step(input mdl_t s, input int w, input bit tse,
                                    input logic a, input logic r, input logic t);
        mdl_t n = s;
        if (!s.booted) begin
            n.booted   = 1'b1;
            n.fetching = 1'b1;
        end else if (s.fetching) begin
            if (a) begin
                n.fetching = 1'b0;
                n.waiting  = 1'b1;
                n.first    = t & tse;
            end
        end else if (s.waiting) begin
            if (r) begin
                n.waiting = 1'b0;
                n.beat    = 0;
            end
        end else if (s.beat == 32 / w - 1) begin
            n.beat = -1;
            if (s.first) begin
                n.first   = 1'b0;
                n.waiting = 1'b1;
            end else begin
                n.fetching = 1'b1;
            end
        end else begin
            n.beat = s.beat + 1;
        end
        return n;
    endfunction

    function automatic obs_t m_obs(input mdl_t s, input int w);
        obs_t o;
        int   bit_idx;
        o       = '0;
        o.cyc   = s.fetching;
        o.init  = s.first;
        o.en    = (s.beat >= 0);
        bit_idx = o.en ? s.beat * w : 0;
        o.cnt   = 5'(bit_idx);
        if (o.en) begin
            o.c0   = (bit_idx == 0);
            o.c1   = (w == 1) && (bit_idx == 1);
            o.c2   = (w == 1) && (bit_idx == 2);
            o.c12  = (bit_idx >= 12);
            o.done = (bit_idx == 32 - w);
            o.pc   = !s.first;
        end
        return o;
    endfunction

    function automatic obs_t mk(input logic cyc, input logic init, input logic en,
                                input int cnt, input logic c0, input logic c1,
                                input logic c2, input logic c12, input logic done,
                                input logic pc);
        return {cyc, init, en, 5'(cnt), c0, c1, c2, c12, done, pc};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < 3; g++) begin
            m[g] = rst ? m_reset() : m_step(m[g], wof(g), tseof(g), ack, rf, ts);
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            check($sformatf("model_dut%0d", g), 32'(obs[g]), 32'(m_obs(m[g], wof(g))));
        end
    end

    initial begin
        vec_t vec [12];
        int   n_c12 [2];
        int   n_c0 [2];
        int   n_c1 [2];
        int   n_pc [2];
        int   n_en, n_pcen, n_init, budget;

        for (int g = 0; g < 3; g++) m[g] = m_reset();

        //          cyc   init  en    cnt  c0    c1    c2    c12   done  pc
        vec[0]  = '{0,  mk(1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0)};
        vec[1]  = '{1,  mk(1'b1,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0)};
        vec[2]  = '{5,  mk(1'b1,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0)};
        vec[3]  = '{6,  mk(1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0)};
        vec[4]  = '{7,  mk(1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0)};
        vec[5]  = '{8,  mk(1'b0,1'b0,1'b1, 0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1)};
        vec[6]  = '{9,  mk(1'b0,1'b0,1'b1, 1, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1)};
        vec[7]  = '{10, mk(1'b0,1'b0,1'b1, 2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1)};
        vec[8]  = '{19, mk(1'b0,1'b0,1'b1,11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1)};
        vec[9]  = '{20, mk(1'b0,1'b0,1'b1,12, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1)};
        vec[10] = '{39, mk(1'b0,1'b0,1'b1,31, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1)};
        vec[11] = '{40, mk(1'b1,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0)};

        tick();
        tick();
        rst = 1'b0;

        // Single-pass instruction: ack in cycle 5, operands ready in cycle 7.
        for (int k = 0; k < 2; k++) begin
            n_c12[k] = 0; n_c0[k] = 0; n_c1[k] = 0; n_pc[k] = 0;
        end
        for (int c = 0; c <= 41; c++) begin
            ack = (c == 5);
            rf  = (c == 7);
            for (int k = 0; k < 12; k++) begin
                if (vec[k].cyc_no == c)
                    check($sformatf("vec_cycle%0d", c), 32'(obs[0]), 32'(vec[k].exp));
            end
            for (int k = 0; k < 2; k++) begin
                n_c12[k] += int'(obs[k].c12);
                n_c0[k]  += int'(obs[k].c0);
                n_c1[k]  += int'(obs[k].c1);
                n_pc[k]  += int'(obs[k].pc);
            end
            tick();
        end
        ack = 1'b0;
        rf  = 1'b0;
        check("w1_cnt12to31_count", 32'(n_c12[0]), 32'd20);
        check("w1_cnt0_count",      32'(n_c0[0]),  32'd1);
        check("w1_pc_en_count",     32'(n_pc[0]),  32'd32);
        check("w4_cnt12to31_count", 32'(n_c12[1]), 32'd5);
        check("w4_cnt0_count",      32'(n_c0[1]),  32'd1);
        check("w4_cnt1_count",      32'(n_c1[1]),  32'd0);
        check("w4_pc_en_count",     32'(n_pc[1]),  32'd8);

        // Two-stage instruction with a delayed second operand-ready.
        ack = 1'b1;
        ts  = 1'b1;
        tick();
        ack = 1'b0;
        ts  = 1'b0;
        check("ts_init_set",      32'(obs[0].init), 32'd1);
        check("ts_cyc_dropped",   32'(obs[0].cyc),  32'd0);
        check("ts_disabled_init", 32'(obs[2].init), 32'd0);
        rf = 1'b1;
        tick();
        rf = 1'b0;
        n_en = 0; n_pcen = 0; n_init = 0;
        for (int i = 0; i < 32; i++) begin
            n_en   += int'(obs[0].en);
            n_pcen += int'(obs[0].pc);
            n_init += int'(obs[0].init);
            tick();
        end
        check("pass1_en_count",   32'(n_en),   32'd32);
        check("pass1_pc_en",      32'(n_pcen), 32'd0);
        check("pass1_init_count", 32'(n_init), 32'd32);
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            n_en += int'(obs[0].en) + int'(obs[0].cyc);
            tick();
        end
        check("wait_rf_idle", 32'(n_en), 32'd0);
        rf = 1'b1;
        tick();
        rf = 1'b0;
        n_pcen = 0; n_init = 0;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("pass2_cnt%0d", i), 32'(obs[0].cnt), 32'(i));
            n_pcen += int'(obs[0].pc);
            n_init += int'(obs[0].init);
            ack = 1'((i % 5) == 2);
            tick();
        end
        ack = 1'b0;
        check("pass2_pc_en",   32'(n_pcen), 32'd32);
        check("pass2_init",    32'(n_init), 32'd0);
        check("pass2_to_fetch", 32'(obs[0].cyc), 32'd1);

        // Operand-ready while fetching must not start a pass.
        rf = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rf = 1'b0;
        check("rf_in_fetch_en",  32'(obs[0].en),  32'd0);
        check("rf_in_fetch_cyc", 32'(obs[0].cyc), 32'd1);

        // Asynchronous reset in the middle of a pass.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        rf  = 1'b1;
        tick();
        rf  = 1'b0;
        budget = 40;
        while (!(obs[0].en === 1'b1 && obs[0].cnt == 5'd17) && budget > 0) begin
            tick();
            budget--;
        end
        check("reach_cnt17", 32'(budget > 0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++)
            check($sformatf("async_rst_dut%0d", g), 32'(obs[g]), 32'd0);
        tick();
        rst = 1'b0;
        check("post_rst_idle", 32'(obs[0]), 32'd0);
        tick();
        check("post_rst_fetch", 32'(obs[0]), 32'(mk(1'b1,1'b0,1'b0,0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0)));

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            ack = ($urandom_range(2) == 0);
            rf  = ($urandom_range(2) == 0);
            ts  = ($urandom_range(1) == 0);
            if ($urandom_range(399) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                for (int g = 0; g < 3; g++)
                    check($sformatf("rand_rst_dut%0d", g), 32'(obs[g]), 32'd0);
            end
            tick();
            rst = 1'b0;
        end

        ack = 1'b0;
        rf  = 1'b0;
        ts  = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
